// File: rtl/combo_pkg.sv
// ============================================================================
//  Module      : combo_pkg
//  Description : Shared types and constants for the combination-lock sender:
//                FSM state encoding, digit geometry and BCD helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package combo_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RST   = 3'd1,
        SEND  = 3'd2,
        CHECK = 3'd3,
        INCR  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int          NUM_DIGITS = 6;
    localparam logic [3:0]  DIGIT_MAX  = 4'd9;
    localparam logic [2:0]  LAST_IDX   = 3'(NUM_DIGITS - 1);

    // Code the lock under test opens on; handy for benches and demos.
    localparam logic [23:0] LOCK_CODE  = 24'h722297;

    // True when every nibble of a code is a legal BCD digit.
    function automatic logic bcd_valid(input logic [23:0] code);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (code[4*i +: 4] > DIGIT_MAX) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // Digit at send position idx; position 0 is digit 1 in [23:20].
    function automatic logic [3:0] digit_at(input logic [23:0] code,
                                            input logic [2:0]  idx);
        logic [3:0] d;
        case (idx)
            3'd0:    d = code[23:20];
            3'd1:    d = code[19:16];
            3'd2:    d = code[15:12];
            3'd3:    d = code[11:8];
            3'd4:    d = code[7:4];
            3'd5:    d = code[3:0];
            default: d = 4'd0;
        endcase
        return d;
    endfunction

endpackage : combo_pkg

`default_nettype wire

// File: rtl/bcd_incr6.sv
// ============================================================================
//  Module      : bcd_incr6
//  Description : Combinational six-digit BCD increment. Digit 6 ([3:0]) is the
//                least significant; carry ripples toward digit 1 ([23:20]).
//                999999 wraps to 000000 with carry_out set.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_incr6
    import combo_pkg::*;
(
    input  logic [23:0] value,
    output logic [23:0] result,
    output logic        carry_out
);

    // carry[i] is the carry into digit position i counted from the LSB.
    logic [NUM_DIGITS:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic [3:0] d;
        logic       wrap;

        assign d    = value[4*i +: 4];
        assign wrap = (d == DIGIT_MAX);

        assign result[4*i +: 4] = carry[i] ? (wrap ? 4'd0 : d + 4'd1) : d;
        assign carry[i+1]       = carry[i] & wrap;
    end

    assign carry_out = carry[NUM_DIGITS];

endmodule : bcd_incr6

`default_nettype wire

// File: rtl/combo_sender.sv
// ============================================================================
//  Module      : combo_sender
//  Description : Presents a six-digit BCD code to a combination lock one digit
//                per cycle, checks the lock's OPEn indication, and optionally
//                brute-forces upward from the loaded code until it opens or
//                the code wraps past 999999.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module combo_sender
    import combo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] code_in,
    input  logic        load,
    input  logic        start,
    input  logic        sweep,
    input  logic        lock_open,
    output logic [3:0]  digit_out,
    output logic        lock_rst,
    output logic [23:0] code_out,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic        load_err
);

    state_t      state;
    state_t      next_state;

    logic [23:0] code;
    logic [2:0]  idx;
    logic        sweep_mode;

    logic [23:0] code_plus1;
    logic        code_carry;
    logic        code_in_ok;

    // Strobes from the control process to the datapath registers.
    logic        load_req;
    logic        run_req;
    logic        idx_clr;
    logic        idx_inc;
    logic        do_incr;
    logic        set_found;
    logic        clr_found;

    assign code_in_ok = bcd_valid(code_in);
    assign code_out   = code;

    bcd_incr6 u_incr (
        .value     (code),
        .result    (code_plus1),
        .carry_out (code_carry)
    );

    // State register; reset overrides everything and lands in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus Moore outputs decoded from state and registers only.
    always_comb begin
        next_state = state;
        digit_out  = 4'd0;
        lock_rst   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        load_req   = 1'b0;
        run_req    = 1'b0;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        do_incr    = 1'b0;
        set_found  = 1'b0;
        clr_found  = 1'b0;

        case (state)
            IDLE: begin
                lock_rst = 1'b1;
                // load has priority; a simultaneous start is dropped.
                if (load) begin
                    load_req = 1'b1;
                end else if (start) begin
                    run_req    = 1'b1;
                    idx_clr    = 1'b1;
                    clr_found  = 1'b1;
                    next_state = SEND;
                end
            end

            RST: begin
                lock_rst   = 1'b1;
                busy       = 1'b1;
                idx_clr    = 1'b1;
                next_state = SEND;
            end

            SEND: begin
                busy      = 1'b1;
                digit_out = digit_at(code, idx);
                if (idx == LAST_IDX) begin
                    idx_clr    = 1'b1;
                    next_state = CHECK;
                end else begin
                    idx_inc = 1'b1;
                end
            end

            CHECK: begin
                busy = 1'b1;
                if (lock_open) begin
                    set_found  = 1'b1;
                    next_state = DONE;
                end else if (!sweep_mode) begin
                    next_state = DONE;
                end else begin
                    next_state = INCR;
                end
            end

            INCR: begin
                // Holding the lock in reset here clears its digit history
                // before the next attempt starts.
                lock_rst = 1'b1;
                busy     = 1'b1;
                do_incr  = 1'b1;
                idx_clr  = 1'b1;
                if (code_carry) begin
                    next_state = DONE;
                end else begin
                    next_state = SEND;
                end
            end

            DONE: begin
                // lock_rst stays low so the lock keeps showing its verdict.
                done = 1'b1;
                if (load) begin
                    load_req   = 1'b1;
                    clr_found  = 1'b1;
                    next_state = IDLE;
                end else if (start) begin
                    run_req    = 1'b1;
                    clr_found  = 1'b1;
                    next_state = RST;
                end
            end

            default: begin
                lock_rst   = 1'b1;
                next_state = IDLE;
            end
        endcase
    end

    // Datapath registers: code, digit index, mode and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            code       <= 24'h000000;
            idx        <= 3'd0;
            sweep_mode <= 1'b0;
            found      <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            if (load_req) begin
                if (code_in_ok) begin
                    code     <= code_in;
                    load_err <= 1'b0;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (do_incr) begin
                code <= code_plus1;
            end

            if (run_req) begin
                sweep_mode <= sweep;
            end

            if (idx_clr) begin
                idx <= 3'd0;
            end else if (idx_inc) begin
                idx <= idx + 3'd1;
            end

            if (set_found) begin
                found <= 1'b1;
            end else if (clr_found) begin
                found <= 1'b0;
            end
        end
    end

endmodule : combo_sender

`default_nettype wire

// File: tb/tb_combo_sender.sv
// ============================================================================
//  Module      : tb_combo_sender
//  Description : Self-checking bench for combo_sender with a behavioural
//                six-digit lock model attached to digit_out / lock_rst.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_combo_sender;
    import combo_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] code_in;
    logic        load;
    logic        start;
    logic        sweep;
    logic        lock_open;
    logic [3:0]  digit_out;
    logic        lock_rst;
    logic [23:0] code_out;
    logic        busy;
    logic        done;
    logic        found;
    logic        load_err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    combo_sender dut (
        .clk       (clk),
        .rst       (rst),
        .code_in   (code_in),
        .load      (load),
        .start     (start),
        .sweep     (sweep),
        .lock_open (lock_open),
        .digit_out (digit_out),
        .lock_rst  (lock_rst),
        .code_out  (code_out),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .load_err  (load_err)
    );

    // Lock model: samples one digit per rising edge while out of reset and
    // shows OPEn (Moore) once six matching digits have arrived.
    logic [23:0] lock_code;
    logic [2:0]  lk_cnt;
    logic        lk_ok;
    logic [23:0] lk_shift;

    initial lock_code = LOCK_CODE;

    always @(posedge clk) begin
        if (lock_rst) begin
            lk_cnt <= 3'd0;
            lk_ok  <= 1'b1;
        end else if (lk_cnt < 3'd6) begin
            lk_shift = lock_code << (4 * lk_cnt);
            lk_ok  <= lk_ok && (digit_out == lk_shift[23:20]);
            lk_cnt <= lk_cnt + 3'd1;
        end
    end

    assign lock_open = (lk_cnt == 3'd6) && lk_ok;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_code(input logic [23:0] c);
        code_in = c;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    typedef struct {
        logic [23:0] code;
        logic        sw;
        logic        exp_found;
        int          exp_cycles;
        logic [23:0] exp_code;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          cyc;
        logic [23:0] digits;

        vecs[0] = '{24'h722297, 1'b0, 1'b1,  7, 24'h722297};
        vecs[1] = '{24'h722296, 1'b0, 1'b0,  7, 24'h722296};
        vecs[2] = '{24'h722290, 1'b1, 1'b1, 63, 24'h722297};
        vecs[3] = '{24'h999998, 1'b1, 1'b0, 16, 24'h000000};
        vecs[4] = '{24'h722287, 1'b1, 1'b1, 87, 24'h722297};
        vecs[5] = '{24'h099999, 1'b0, 1'b0,  7, 24'h099999};

        rst = 1'b1; code_in = 24'h0; load = 1'b0; start = 1'b0; sweep = 1'b0;
        tick();
        tick();
        check("reset_flags", {lock_rst, digit_out, busy, done, found, load_err}, 9'h100);
        check("reset_code", code_out, 24'h000000);
        rst = 1'b0;

        // Valid load, then an illegal nibble that must be rejected.
        load_code(24'h123456);
        check("load_ok_code", code_out, 24'h123456);
        check("load_ok_err", load_err, 1'b0);
        load_code(24'h7A2297);
        check("bad_load_err", load_err, 1'b1);
        check("bad_load_code", code_out, 24'h123456);

        // load and start together: load wins, FSM stays in IDLE.
        code_in = 24'h654321; load = 1'b1; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        check("ldst_code", code_out, 24'h654321);
        check("ldst_err_clr", load_err, 1'b0);
        check("ldst_idle", {busy, lock_rst}, 2'b01);
        tick();
        check("ldst_still_idle", {busy, done, lock_rst}, 3'b001);

        // Table of attempts.
        for (int v = 0; v < 6; v++) begin
            load_code(vecs[v].code);
            check("v_load_flags", {done, found, load_err}, 3'b000);
            check("v_load_code", code_out, vecs[v].code);

            sweep = vecs[v].sw; start = 1'b1;
            tick();
            start = 1'b0;
            cyc    = 0;
            digits = {20'h0, digit_out};
            check("v_busy", busy, 1'b1);
            while (!done && cyc < 300) begin
                tick();
                cyc++;
                if (cyc <= 5) digits = {digits[19:0], digit_out};
            end
            check("v_digits", digits, vecs[v].code);
            check("v_cycles", cyc, vecs[v].exp_cycles);
            check("v_found", found, vecs[v].exp_found);
            check("v_code_out", code_out, vecs[v].exp_code);
            check("v_lock_shows", lock_open, vecs[v].exp_found);
            check("v_done_idle", {busy, lock_rst, digit_out}, 6'b000000);
        end

        // DONE + start goes through RST and retries.
        load_code(24'h722297);
        sweep = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 50) begin tick(); cyc++; end
        check("retry_first_found", found, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rst_state", {busy, done, found, lock_rst}, 4'b1001);
        tick();
        check("rst_then_send", {lock_rst, digit_out}, 5'h07);
        cyc = 1;
        while (!done && cyc < 50) begin tick(); cyc++; end
        check("retry_cycles", cyc, 8);
        check("retry_found", found, 1'b1);

        // Busy ignores load/start; rst mid-SEND aborts everything.
        load_code(24'h722297);
        load_code(24'hB00000);
        check("pre_abort_err", load_err, 1'b1);
        sweep = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        code_in = 24'h111111; load = 1'b1; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        check("busy_ignores_load", code_out, 24'h722297);
        check("busy_digit2", {busy, digit_out}, 5'h12);
        tick();
        tick();
        check("send_idx3_digit", digit_out, 4'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_flags", {lock_rst, digit_out, busy, done, found, load_err}, 9'h100);
        check("abort_code", code_out, 24'h000000);
        tick();
        check("abort_stays_idle", {busy, lock_rst}, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_combo_sender

`default_nettype wire
